// File: rtl/cpu5_mcdec.sv
// cpu5_mcdec: multi-cycle CPU control unit. A Moore FSM walks each instruction
// through fetch, decode, execute/memory and write-back; the only outputs that
// look at an input are the mem_rdy-qualified strobes in FETCH and MEMWR.
module cpu5_mcdec #(
   parameter int OP_W    = 7,
   parameter int ALUOP_W = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [OP_W-1:0]    op,
   input  logic               mem_rdy,
   output logic               irwrite,
   output logic               pcwrite,
   output logic               branch,
   output logic               iord,
   output logic               memread,
   output logic               memwrite,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               regdst,
   output logic               alusrca,
   output logic               jump,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [ALUOP_W-1:0] aluop,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [3:0]         state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_EXECI   = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_ILLEGAL = 4'd11
   } state_t;

   typedef struct packed {
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       regdst;
      logic       alusrca;
      logic       jump;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   // Opcodes are compared zero-extended, so any set bit above op[6] makes
   // the opcode unsupported.
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(7'b0000011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(7'b0100011);
   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(7'b0110011);
   localparam logic [OP_W-1:0] OP_ITYPE = OP_W'(7'b0010011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(7'b1100011);
   localparam logic [OP_W-1:0] OP_JAL   = OP_W'(7'b1101111);

   state_t st, st_nxt;
   ctrl_t  c;

   // State register; reset abandons whatever access was in flight.
   always_ff @(posedge clk) begin
      if (!resetn) st <= S_FETCH;
      else         st <= st_nxt;
   end

   // Next-state and control decode; everything not named for a state is 0.
   always_comb begin
      st_nxt = st;
      c      = '0;
      case (st)
         S_FETCH: begin
            c.memread = 1'b1;
            c.alusrcb = 2'b01;
            c.irwrite = mem_rdy;
            c.pcwrite = mem_rdy;
            if (mem_rdy) st_nxt = S_DECODE;
         end
         S_DECODE: begin
            c.alusrcb = 2'b11;
            if (op == OP_LW || op == OP_SW) st_nxt = S_MEMADR;
            else if (op == OP_RTYPE)        st_nxt = S_EXEC;
            else if (op == OP_ITYPE)        st_nxt = S_EXECI;
            else if (op == OP_BEQ)          st_nxt = S_BRANCH;
            else if (op == OP_JAL)          st_nxt = S_JUMP;
            else                            st_nxt = S_ILLEGAL;
         end
         S_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            // op is re-sampled here; anything but a load/store is trapped.
            if (op == OP_LW)      st_nxt = S_MEMRD;
            else if (op == OP_SW) st_nxt = S_MEMWR;
            else                  st_nxt = S_ILLEGAL;
         end
         S_MEMRD: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
            if (mem_rdy) st_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            c.regwrite   = 1'b1;
            c.memtoreg   = 1'b1;
            c.instr_done = 1'b1;
            st_nxt       = S_FETCH;
         end
         S_MEMWR: begin
            c.memwrite   = 1'b1;
            c.iord       = 1'b1;
            c.instr_done = mem_rdy;
            if (mem_rdy) st_nxt = S_FETCH;
         end
         S_EXEC: begin
            c.alusrca = 1'b1;
            c.aluop   = 2'b10;
            st_nxt    = S_ALUWB;
         end
         S_EXECI: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.aluop   = 2'b11;
            st_nxt    = S_ALUWB;
         end
         S_ALUWB: begin
            c.regwrite   = 1'b1;
            c.regdst     = 1'b1;
            c.instr_done = 1'b1;
            st_nxt       = S_FETCH;
         end
         S_BRANCH: begin
            c.alusrca    = 1'b1;
            c.aluop      = 2'b01;
            c.branch     = 1'b1;
            c.pcsrc      = 2'b01;
            c.instr_done = 1'b1;
            st_nxt       = S_FETCH;
         end
         S_JUMP: begin
            c.pcwrite    = 1'b1;
            c.jump       = 1'b1;
            c.pcsrc      = 2'b10;
            c.regwrite   = 1'b1;
            c.regdst     = 1'b1;
            c.instr_done = 1'b1;
            st_nxt       = S_FETCH;
         end
         S_ILLEGAL: begin
            // Trap: parked here until reset.
            c.illegal_op = 1'b1;
         end
         default: st_nxt = S_FETCH;
      endcase
   end

   assign irwrite    = c.irwrite;
   assign pcwrite    = c.pcwrite;
   assign branch     = c.branch;
   assign iord       = c.iord;
   assign memread    = c.memread;
   assign memwrite   = c.memwrite;
   assign memtoreg   = c.memtoreg;
   assign regwrite   = c.regwrite;
   assign regdst     = c.regdst;
   assign alusrca    = c.alusrca;
   assign jump       = c.jump;
   assign alusrcb    = c.alusrcb;
   assign pcsrc      = c.pcsrc;
   assign aluop      = ALUOP_W'(c.aluop);
   assign instr_done = c.instr_done;
   assign illegal_op = c.illegal_op;
   assign state      = st;

endmodule

// File: tb/tb_cpu5_mcdec.sv
// Directed bench for cpu5_mcdec: walks each instruction class cycle by cycle
// and compares state plus the full control vector against hand-written tables.
module tb_cpu5_mcdec;

   localparam logic [6:0] LW    = 7'b0000011;
   localparam logic [6:0] SW    = 7'b0100011;
   localparam logic [6:0] RTYPE = 7'b0110011;
   localparam logic [6:0] ITYPE = 7'b0010011;
   localparam logic [6:0] BEQ   = 7'b1100011;
   localparam logic [6:0] JAL   = 7'b1101111;
   localparam logic [6:0] BAD   = 7'b1111111;

   logic       clk = 1'b0;
   logic       resetn;
   logic [6:0] op;
   logic       mem_rdy;
   logic       irwrite, pcwrite, branch, iord, memread, memwrite, memtoreg;
   logic       regwrite, regdst, alusrca, jump, instr_done, illegal_op;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic [3:0] state;

   int n_chk = 0;
   int n_err = 0;

   cpu5_mcdec #(.OP_W(7), .ALUOP_W(2)) dut (
      .clk(clk), .resetn(resetn), .op(op), .mem_rdy(mem_rdy),
      .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch), .iord(iord),
      .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
      .regwrite(regwrite), .regdst(regdst), .alusrca(alusrca), .jump(jump),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
      .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   // Observed control vector, same field order as exp_ctl below.
   wire [18:0] ctl = {irwrite, pcwrite, branch, iord, memread, memwrite,
                      memtoreg, regwrite, regdst, alusrca, jump,
                      alusrcb, pcsrc, aluop, instr_done, illegal_op};

   // Expected controls per state, straight from the control table.
   function automatic logic [18:0] exp_ctl(int s, bit r);
      logic irw, pcw, br, io, mrd, mwr, m2r, rw, rd, asa, jmp, dn, il;
      logic [1:0] asb, pcs, aop;
      {irw, pcw, br, io, mrd, mwr, m2r, rw, rd, asa, jmp, dn, il} = '0;
      asb = 2'b00; pcs = 2'b00; aop = 2'b00;
      case (s)
         0:  begin mrd = 1; asb = 2'b01; irw = r; pcw = r; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; io = 1; end
         4:  begin rw = 1; m2r = 1; dn = 1; end
         5:  begin mwr = 1; io = 1; dn = r; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rd = 1; dn = 1; end
         8:  begin asa = 1; asb = 2'b10; aop = 2'b11; end
         9:  begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; dn = 1; end
         10: begin pcw = 1; jmp = 1; pcs = 2'b10; rw = 1; rd = 1; dn = 1; end
         11: il = 1;
         default: ;
      endcase
      return {irw, pcw, br, io, mrd, mwr, m2r, rw, rd, asa, jmp,
              asb, pcs, aop, dn, il};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: apply mem_rdy, check current state/controls, advance a clock.
   task automatic cyc(input string tag, input int es, input bit rdy);
      mem_rdy = rdy;
      #1;
      chk({tag, ".st"}, 32'(state), 32'(es));
      chk({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl(es, rdy)));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; mem_rdy = 1'b0; op = LW;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      // Reset state, FETCH stalled by mem_rdy=0.
      cyc("rst", 0, 0);

      // LW, mem_rdy always high: 0,1,2,3,4 then back to FETCH.
      op = LW;
      cyc("lw0", 0, 1); cyc("lw1", 1, 1); cyc("lw2", 2, 1);
      cyc("lw3", 3, 1); cyc("lw4", 4, 1);

      // SW with two wait cycles in MEMWR; op change there must not matter.
      op = SW;
      cyc("sw0", 0, 1); cyc("sw1", 1, 1); cyc("sw2", 2, 1);
      op = RTYPE;
      cyc("sw5a", 5, 0); cyc("sw5b", 5, 0); cyc("sw5c", 5, 1);

      // R-type then I-type back to back.
      op = RTYPE;
      cyc("r0", 0, 1); cyc("r1", 1, 1); cyc("r6", 6, 1); cyc("r7", 7, 1);
      op = ITYPE;
      cyc("i0", 0, 1); cyc("i1", 1, 1); cyc("i8", 8, 1); cyc("i7", 7, 1);

      // BEQ with one FETCH stall, then JAL.
      op = BEQ;
      cyc("b0s", 0, 0); cyc("b0", 0, 1); cyc("b1", 1, 1); cyc("b9", 9, 1);
      op = JAL;
      cyc("j0", 0, 1); cyc("j1", 1, 1); cyc("j10", 10, 1);

      // LW with one MEMRD stall.
      op = LW;
      cyc("lws0", 0, 1); cyc("lws1", 1, 1); cyc("lws2", 2, 1);
      cyc("lws3a", 3, 0); cyc("lws3b", 3, 1); cyc("lws4", 4, 1);

      // Unsupported opcode: trapped, held through op/mem_rdy activity.
      op = BAD;
      cyc("il0", 0, 1); cyc("il1", 1, 1);
      for (int k = 0; k < 12; k++) begin
         op = (k % 2 == 0) ? LW : BAD;
         cyc("ill", 11, k[0]);
      end
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      mem_rdy = 1'b0;
      #1;
      chk("ilrst.st", 32'(state), 32'd0);
      chk("ilrst.ill", 32'(illegal_op), 32'd0);
      chk("ilrst.done", 32'(instr_done), 32'd0);

      // Reset while MEMRD is stalled: back to FETCH, no write afterwards.
      op = LW;
      cyc("rm0", 0, 1); cyc("rm1", 1, 1); cyc("rm2", 2, 1);
      mem_rdy = 1'b0;
      resetn  = 1'b0;
      #1;
      chk("rm3.st", 32'(state), 32'd3);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cyc("rmr0", 0, 0);
      cyc("rmr1", 0, 0);
      chk("rm.regwrite", 32'(regwrite), 32'd0);
      chk("rm.memwrite", 32'(memwrite), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
